scanline_ring_buffer: RTL and testbench

//  Parametrised single-clock scanline buffer holding NUM_LINES complete video lines in a ring.

---
 rtl/scanline_ring_buffer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_scanline_ring_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/scanline_ring_buffer.sv
// scanline_ring_buffer
//   Single-clock ring of NUM_LINES video lines between the mixer pixel stream
//   and the framebuffer stream. Only whole lines become visible to the reader.
//   Each stored pixel is replayed SCALE_X beats for horizontal upscaling.
// Ports
//   iCLK, iRESETn              clock (rising edge), async active-low reset
//   iPIX_RGB/WRITE/START       write pixel, strobe, first-pixel-of-line marker
//   oPIX_FULL                  every slot holds a committed line
//   oFB_RGB/START/DATAVALID    read beat, first-beat-of-line, beat valid
//   iFB_READY                  downstream accepts the current beat
//   oLINES_USED                committed lines not yet fully read out
//   oOVERRUN, oSHORT_LINE      1-cycle error pulses (write dropped / line restarted)
module scanline_ring_buffer #(
  parameter int PIX_WIDTH   = 15,
  parameter int LINE_PIXELS = 640,
  parameter int NUM_LINES   = 2,
  parameter int SCALE_X     = 1
) (
  input  logic                             iCLK,
  input  logic                             iRESETn,
  input  logic [PIX_WIDTH-1:0]             iPIX_RGB,
  input  logic                             iPIX_WRITE,
  input  logic                             iPIX_START,
  output logic                             oPIX_FULL,
  output logic                             oFB_START,
  output logic [PIX_WIDTH-1:0]             oFB_RGB,
  output logic                             oFB_DATAVALID,
  input  logic                             iFB_READY,
  output logic [$clog2(NUM_LINES+1)-1:0]   oLINES_USED,
  output logic                             oOVERRUN,
  output logic                             oSHORT_LINE
);

  localparam int IDX_W  = $clog2(LINE_PIXELS);
  localparam int SLOT_W = $clog2(NUM_LINES);
  localparam int CNT_W  = $clog2(NUM_LINES+1);
  localparam int REP_W  = $clog2(SCALE_X) + 1;
  localparam int DEPTH  = NUM_LINES * LINE_PIXELS;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {W_IDLE, W_FILL} wState_t;
  typedef enum logic {R_IDLE, R_LINE} rState_t;

  // Flat RAM address of a pixel inside a line slot.
  function automatic logic [ADDR_W-1:0] slotAddr(input logic [SLOT_W-1:0] slot,
                                                 input logic [IDX_W-1:0]  idx);
    return ADDR_W'(slot) * ADDR_W'(LINE_PIXELS) + ADDR_W'(idx);
  endfunction

  // Slot pointer increment with explicit wrap (NUM_LINES need not be a power of 2).
  function automatic logic [SLOT_W-1:0] slotNext(input logic [SLOT_W-1:0] slot);
    return (slot == SLOT_W'(NUM_LINES-1)) ? {SLOT_W{1'b0}} : slot + SLOT_W'(1);
  endfunction

  logic [PIX_WIDTH-1:0] mem [DEPTH];
  logic [PIX_WIDTH-1:0] ramQ_r;

  wState_t              wState_r;
  logic [SLOT_W-1:0]    wrSlot_r;
  logic [IDX_W-1:0]     wrIdx_r;
  logic                 overrun_r, shortLine_r;
  logic [CNT_W-1:0]     cnt_r, linesIssued_r, cntNext_s, issuedNext_s;
  logic                 full_r;

  rState_t              rState_r;
  logic [SLOT_W-1:0]    rdSlot_r;
  logic [IDX_W-1:0]     rdIdx_r;
  logic                 rdPend_r, pendFirst_r, pendLast_r;

  logic                 outValid_r, outStart_r, outLast_r;
  logic [PIX_WIDTH-1:0] outRgb_r;
  logic [REP_W-1:0]     beat_r;
  logic                 skValid_r, skFirst_r, skLast_r;
  logic [PIX_WIDTH-1:0] skRgb_r;

  logic                 startLine_s, fillPix_s, commit_s, wrEn_s;
  logic [ADDR_W-1:0]    wrAddr_s, rdAddr_s;
  logic                 availNz_s, issue_s, issueLast_s;
  logic [1:0]           occ_s, occAfter_s;
  logic                 xfer_s, pop_s, release_s, loadOut_s;
  logic [PIX_WIDTH-1:0] srcRgb_s;
  logic                 srcFirst_s, srcLast_s;

  // A START restarts the line from W_FILL even though the ring may look full:
  // the slot being filled is always a free one.
  assign startLine_s = iPIX_WRITE & iPIX_START & ((wState_r == W_FILL) | ~full_r);
  assign fillPix_s   = (wState_r == W_FILL) & iPIX_WRITE & ~iPIX_START;
  assign commit_s    = fillPix_s & (wrIdx_r == IDX_W'(LINE_PIXELS-1));
  assign wrEn_s      = startLine_s | fillPix_s;
  assign wrAddr_s    = slotAddr(wrSlot_r, startLine_s ? {IDX_W{1'b0}} : wrIdx_r);

  // Reader may fetch while some committed line is not yet completely fetched.
  // Fetches are limited so output register + skid + in-flight read never exceed 2.
  assign availNz_s   = (cnt_r != linesIssued_r);
  assign xfer_s      = outValid_r & iFB_READY;
  assign pop_s       = xfer_s & (beat_r == REP_W'(SCALE_X-1));
  assign release_s   = pop_s & outLast_r;
  assign occ_s       = {1'b0, outValid_r} + {1'b0, skValid_r} + {1'b0, rdPend_r};
  assign occAfter_s  = occ_s - {1'b0, pop_s};
  assign issue_s     = (rState_r == R_LINE) & availNz_s & (occAfter_s < 2'd2);
  assign issueLast_s = issue_s & (rdIdx_r == IDX_W'(LINE_PIXELS-1));
  assign rdAddr_s    = slotAddr(rdSlot_r, rdIdx_r);
  assign loadOut_s   = (~outValid_r | pop_s) & (skValid_r | rdPend_r);

  // Next pixel for the output register: the skid entry is older than the RAM word.
  always_comb begin
    srcRgb_s   = ramQ_r;
    srcFirst_s = pendFirst_r;
    srcLast_s  = pendLast_r;
    if (skValid_r) begin
      srcRgb_s   = skRgb_r;
      srcFirst_s = skFirst_r;
      srcLast_s  = skLast_r;
    end else begin
      srcRgb_s   = ramQ_r;
      srcFirst_s = pendFirst_r;
      srcLast_s  = pendLast_r;
    end
  end

  // Next committed-line count and fully-fetched-line count.
  always_comb begin
    cntNext_s    = cnt_r;
    issuedNext_s = linesIssued_r;
    case ({commit_s, release_s})
      2'b10:   cntNext_s = cnt_r + CNT_W'(1);
      2'b01:   cntNext_s = cnt_r - CNT_W'(1);
      default: cntNext_s = cnt_r;
    endcase
    case ({issueLast_s, release_s})
      2'b10:   issuedNext_s = linesIssued_r + CNT_W'(1);
      2'b01:   issuedNext_s = linesIssued_r - CNT_W'(1);
      default: issuedNext_s = linesIssued_r;
    endcase
  end

  // Line storage with registered read port; contents are never reset.
  always_ff @(posedge iCLK) begin
    if (wrEn_s) begin
      mem[wrAddr_s] <= iPIX_RGB;
    end
    if (issue_s) begin
      ramQ_r <= mem[rdAddr_s];
    end
  end

  // Write FSM: fill one slot, commit on its last pixel, flag drops and restarts.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      wState_r    <= W_IDLE;
      wrSlot_r    <= {SLOT_W{1'b0}};
      wrIdx_r     <= {IDX_W{1'b0}};
      overrun_r   <= 1'b0;
      shortLine_r <= 1'b0;
    end else begin
      overrun_r   <= (wState_r == W_IDLE) & iPIX_WRITE & full_r;
      shortLine_r <= (wState_r == W_FILL) & iPIX_WRITE & iPIX_START;
      case (wState_r)
        W_IDLE: begin
          if (startLine_s) begin
            wState_r <= W_FILL;
            wrIdx_r  <= IDX_W'(1);
          end
        end
        W_FILL: begin
          if (startLine_s) begin
            wrIdx_r <= IDX_W'(1);
          end else if (commit_s) begin
            wrIdx_r  <= {IDX_W{1'b0}};
            wrSlot_r <= slotNext(wrSlot_r);
            wState_r <= W_IDLE;
          end else if (fillPix_s) begin
            wrIdx_r <= wrIdx_r + IDX_W'(1);
          end
        end
        default: wState_r <= W_IDLE;
      endcase
    end
  end

  // Occupancy bookkeeping shared by both sides.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      cnt_r         <= {CNT_W{1'b0}};
      linesIssued_r <= {CNT_W{1'b0}};
      full_r        <= 1'b0;
    end else begin
      cnt_r         <= cntNext_s;
      linesIssued_r <= issuedNext_s;
      full_r        <= (cntNext_s == CNT_W'(NUM_LINES));
    end
  end

  // Read FSM: walks committed slots in commit order issuing RAM reads.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      rState_r    <= R_IDLE;
      rdSlot_r    <= {SLOT_W{1'b0}};
      rdIdx_r     <= {IDX_W{1'b0}};
      rdPend_r    <= 1'b0;
      pendFirst_r <= 1'b0;
      pendLast_r  <= 1'b0;
    end else begin
      rdPend_r    <= issue_s;
      pendFirst_r <= issue_s & (rdIdx_r == {IDX_W{1'b0}});
      pendLast_r  <= issueLast_s;
      case (rState_r)
        R_IDLE:  if (availNz_s) rState_r <= R_LINE;
        R_LINE:  if (!availNz_s) rState_r <= R_IDLE;
        default: rState_r <= R_IDLE;
      endcase
      if (issueLast_s) begin
        rdIdx_r  <= {IDX_W{1'b0}};
        rdSlot_r <= slotNext(rdSlot_r);
      end else if (issue_s) begin
        rdIdx_r <= rdIdx_r + IDX_W'(1);
      end
    end
  end

  // Output beat register with SCALE_X replay, plus a one-entry skid for stalls.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      outValid_r <= 1'b0;
      outStart_r <= 1'b0;
      outLast_r  <= 1'b0;
      outRgb_r   <= {PIX_WIDTH{1'b0}};
      beat_r     <= {REP_W{1'b0}};
      skValid_r  <= 1'b0;
      skFirst_r  <= 1'b0;
      skLast_r   <= 1'b0;
      skRgb_r    <= {PIX_WIDTH{1'b0}};
    end else begin
      if (loadOut_s) begin
        outValid_r <= 1'b1;
        outRgb_r   <= srcRgb_s;
        outStart_r <= srcFirst_s;
        outLast_r  <= srcLast_s;
        beat_r     <= {REP_W{1'b0}};
      end else if (pop_s) begin
        outValid_r <= 1'b0;
        outStart_r <= 1'b0;
        beat_r     <= {REP_W{1'b0}};
      end else if (xfer_s) begin
        outStart_r <= 1'b0;
        beat_r     <= beat_r + REP_W'(1);
      end
      // A full skid with a held output implies no read is in flight.
      if (skValid_r) begin
        if (loadOut_s) begin
          skValid_r <= rdPend_r;
          skRgb_r   <= ramQ_r;
          skFirst_r <= pendFirst_r;
          skLast_r  <= pendLast_r;
        end
      end else if (rdPend_r && !loadOut_s) begin
        skValid_r <= 1'b1;
        skRgb_r   <= ramQ_r;
        skFirst_r <= pendFirst_r;
        skLast_r  <= pendLast_r;
      end
    end
  end

  assign oPIX_FULL     = full_r;
  assign oLINES_USED   = cnt_r;
  assign oOVERRUN      = overrun_r;
  assign oSHORT_LINE   = shortLine_r;
  assign oFB_DATAVALID = outValid_r;
  assign oFB_START     = outStart_r;
  assign oFB_RGB       = outRgb_r;

endmodule

// File: tb/tb_scanline_ring_buffer.sv
// Bench for scanline_ring_buffer: two instances (A: 4 px, 2 slots, x1;
// B: 4 px, 3 slots, x2) share one input stream and are compared each cycle
// against a line-level reference model.
module tb_scanline_ring_buffer;

  logic        clk = 1'b0;
  logic        rstN;
  logic        pixWrite, pixStart, fbReady;
  logic [14:0] pixRgb;
  logic        aFull, aStart, aValid, aOv, aSh;
  logic        bFull, bStart, bValid, bOv, bSh;
  logic [14:0] aRgb, bRgb;
  logic [1:0]  aUsed, bUsed;

  int tests = 0;
  int fails = 0;

  int mUsed [2], mFill [2], pLen [2], beatIdx [2], expOv [2], expSh [2], waitCyc [2];
  int part [2][4];
  int eb [2][64];
  int eh [2], et [2];
  int tg = 0;

  always #5 clk = ~clk;

  scanline_ring_buffer #(.PIX_WIDTH(15), .LINE_PIXELS(4), .NUM_LINES(2), .SCALE_X(1)) dutA (
    .iCLK(clk), .iRESETn(rstN), .iPIX_RGB(pixRgb), .iPIX_WRITE(pixWrite), .iPIX_START(pixStart),
    .oPIX_FULL(aFull), .oFB_START(aStart), .oFB_RGB(aRgb), .oFB_DATAVALID(aValid),
    .iFB_READY(fbReady), .oLINES_USED(aUsed), .oOVERRUN(aOv), .oSHORT_LINE(aSh));

  scanline_ring_buffer #(.PIX_WIDTH(15), .LINE_PIXELS(4), .NUM_LINES(3), .SCALE_X(2)) dutB (
    .iCLK(clk), .iRESETn(rstN), .iPIX_RGB(pixRgb), .iPIX_WRITE(pixWrite), .iPIX_START(pixStart),
    .oPIX_FULL(bFull), .oFB_START(bStart), .oFB_RGB(bRgb), .oFB_DATAVALID(bValid),
    .iFB_READY(fbReady), .oLINES_USED(bUsed), .oOVERRUN(bOv), .oSHORT_LINE(bSh));

  function automatic int nlOf(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int sxOf(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mUsed[d] = 0; mFill[d] = 0; pLen[d] = 0; beatIdx[d] = 0;
      expOv[d] = 0; expSh[d] = 0; waitCyc[d] = 0; eh[d] = 0; et[d] = 0;
    end
  endtask

  // Compare one instance against the model, then advance the model across the coming edge.
  task automatic modelDut(input int d, input logic v, input logic st, input logic [14:0] px,
                          input logic [1:0] u, input logic full, input logic ov, input logic sh);
    int rel, com, sx, nl;
    sx = sxOf(d); nl = nlOf(d); rel = 0; com = 0;
    chk("lines_used", d, 32'(u), 32'(mUsed[d]));
    chk("pix_full", d, 32'(full), 32'(mUsed[d] == nl));
    chk("overrun", d, 32'(ov), 32'(expOv[d]));
    chk("short_line", d, 32'(sh), 32'(expSh[d]));
    if (v) begin
      if (et[d] == eh[d]) chk("spurious_valid", d, 32'(v), 32'd0);
      else chk("beat", d, {16'd0, st, px}, 32'(eb[d][eh[d] % 64]));
    end
    if (beatIdx[d] > 0) chk("no_bubble", d, 32'(v), 32'd1);
    if (!v && et[d] != eh[d] && beatIdx[d] == 0) begin
      waitCyc[d]++;
      chk("first_latency", d, 32'(waitCyc[d] <= 3), 32'd1);
    end else begin
      waitCyc[d] = 0;
    end
    if (v && fbReady && et[d] != eh[d]) begin
      eh[d]++;
      beatIdx[d]++;
      if (beatIdx[d] == 4 * sx) begin
        beatIdx[d] = 0;
        rel = 1;
      end
    end
    expOv[d] = 0;
    expSh[d] = 0;
    if (pixWrite) begin
      if (mFill[d] == 0) begin
        if (mUsed[d] == nl) expOv[d] = 1;
        else if (pixStart) begin
          mFill[d] = 1; part[d][0] = int'(pixRgb); pLen[d] = 1;
        end
      end else if (pixStart) begin
        expSh[d] = 1; part[d][0] = int'(pixRgb); pLen[d] = 1;
      end else begin
        part[d][pLen[d]] = int'(pixRgb);
        pLen[d]++;
        if (pLen[d] == 4) begin
          for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < sx; k++) begin
              eb[d][et[d] % 64] = ((i == 0 && k == 0) ? 32'h8000 : 0) | part[d][i];
              et[d]++;
            end
          end
          com = 1; mFill[d] = 0; pLen[d] = 0;
        end
      end
    end
    mUsed[d] = mUsed[d] + com - rel;
  endtask

  task automatic cyc(input logic w, input logic s, input logic [14:0] rgb, input logic r);
    pixWrite = w; pixStart = s; pixRgb = rgb; fbReady = r;
    @(negedge clk);
    modelDut(0, aValid, aStart, aRgb, aUsed, aFull, aOv, aSh);
    modelDut(1, bValid, bStart, bRgb, bUsed, bFull, bOv, bSh);
    @(posedge clk);
    #1;
  endtask

  // mode: 0 ready low, 1 ready high, 2 toggle each cycle
  function automatic logic rdyOf(input int mode);
    if (mode == 2) begin
      tg = 1 - tg;
      return tg[0];
    end
    return (mode == 1);
  endfunction

  task automatic writeLine(input int base, input int mode);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, (i == 0), (base < 0) ? 15'($urandom) : 15'(base + i), rdyOf(mode));
    end
  endtask

  task automatic drain(input int mode);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      cyc(1'b0, 1'b0, 15'd0, (k < 20) ? rdyOf(mode) : 1'b1);
      done = (eh[0] == et[0]) && (eh[1] == et[1]) && (mUsed[0] == 0) && (mUsed[1] == 0)
             && !aValid && !bValid;
    end
    chk("drain_done", -1, 32'(done), 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_valid"}, 0, 32'(aValid), 32'd0);
    chk({tag, "_start"}, 0, 32'(aStart), 32'd0);
    chk({tag, "_full"}, 0, 32'(aFull), 32'd0);
    chk({tag, "_used"}, 0, 32'(aUsed), 32'd0);
    chk({tag, "_valid"}, 1, 32'(bValid), 32'd0);
    chk({tag, "_start"}, 1, 32'(bStart), 32'd0);
    chk({tag, "_full"}, 1, 32'(bFull), 32'd0);
    chk({tag, "_used"}, 1, 32'(bUsed), 32'd0);
  endtask

  initial begin
    rstN = 1'b0; pixWrite = 1'b0; pixStart = 1'b0; pixRgb = 15'd0; fbReady = 1'b0;
    modelReset();
    #2;
    checkResetOutputs("rst");
    chk("rst_rgb", 0, 32'(aRgb), 32'd0);
    chk("rst_rgb", 1, 32'(bRgb), 32'd0);
    chk("rst_pulses", 0, {30'd0, aOv, aSh}, 32'd0);
    chk("rst_pulses", 1, {30'd0, bOv, bSh}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rstN = 1'b1;

    // T1/T2: one line with ready high, fixed pixel values
    writeLine(1, 1);
    drain(1);
    writeLine(15'h0A, 1);
    drain(1);

    // T3: fill with ready low, extra write overruns, then drain in order
    for (int l = 0; l < 3; l++) writeLine(-1, 0);
    cyc(1'b1, 1'b1, 15'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 15'd0, 1'b0);
    drain(1);

    // T4: ready toggling every cycle
    for (int l = 0; l < 3; l++) writeLine(-1, 2);
    drain(2);

    // T5: restart mid-line
    cyc(1'b1, 1'b1, 15'h7001, 1'b1);
    cyc(1'b1, 1'b0, 15'h7002, 1'b1);
    writeLine(-1, 1);
    drain(1);

    // T6: asynchronous reset while a line streams out and another is filling
    writeLine(-1, 1);
    cyc(1'b1, 1'b1, 15'($urandom), 1'b1);
    cyc(1'b1, 1'b0, 15'($urandom), 1'b1);
    pixWrite = 1'b0; pixStart = 1'b0;
    #2 rstN = 1'b0;
    #1 checkResetOutputs("async_rst");
    modelReset();
    @(posedge clk); #1;
    rstN = 1'b1;
    writeLine(-1, 1);
    drain(1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 4) != 0, ($urandom % 8) == 0, 15'($urandom), ($urandom % 3) != 0);
    end
    drain(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
